// File: rtl/pipe_pkg.sv
// pipe_pkg: stage register states plus the RV32E per-stage payload structs and their kill masks.
package pipe_pkg;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} stage_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [3:0]  rd;
        logic [3:0]  alu_op;
        logic [2:0]  funct3;
        logic        mem_re;
        logic        mem_we;
        logic        regfile_we;
        logic        is_branch;
        logic        is_jump;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [3:0]  rd;
        logic        regfile_we;
    } memex_wb_t;

    // Fetch carries no side effects, so nothing needs clearing on a squash.
    localparam logic [$bits(if_id_t)-1:0]    IF_ID_KILL_MASK    = '0;
    // mem_re, mem_we, regfile_we, is_branch and is_jump occupy the low five bits.
    localparam logic [$bits(id_ex_t)-1:0]    ID_EX_KILL_MASK    = 144'h1F;
    localparam logic [$bits(memex_wb_t)-1:0] MEMEX_WB_KILL_MASK = 69'h1;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: one-entry data+kill store that catches the entry accepted as out_ready falls.
module pipe_skid_buf #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              in_kill,
    input  logic [DATA_W-1:0] in_data,
    output logic              kill,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            kill <= 1'b0;
            data <= RESET_VAL;
        end else if (load) begin
            kill <= in_kill;
            data <= in_data;
        end
    end

endmodule

// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: valid/ready pipeline register with stall, flush and squash-as-bubble.
// Define PIPE_SKID_EN for a registered in_ready backed by a one-entry skid buffer.
module pipeline_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 32*4+16,
    parameter logic [DATA_W-1:0] KILL_MASK = '0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_kill,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_killed,
    output logic [DATA_W-1:0] out_data
);

    stage_state_e      state, state_nx;
    logic              main_kill, skid_kill;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              in_xfer, load_main, load_skid, skid_to_main;

    assign in_xfer      = in_valid && in_ready && !flush;
    assign load_main    = in_xfer && (state == EMPTY || (state == FULL && out_ready));
    assign load_skid    = in_xfer && state == FULL && !out_ready;
    assign skid_to_main = state == SKID && out_ready;

`ifdef PIPE_SKID_EN
    pipe_skid_buf #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (load_skid),
        .in_kill (in_kill),
        .in_data (in_data),
        .kill    (skid_kill),
        .data    (skid_data)
    );
`else
    assign skid_kill = 1'b0;
    assign skid_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = EMPTY;
        else
            case (state)
                EMPTY:   state_nx = in_xfer ? FULL : EMPTY;
                FULL:    state_nx = load_skid ? SKID : (out_ready && !in_xfer) ? EMPTY : FULL;
                SKID:    state_nx = out_ready ? FULL : SKID;
                default: state_nx = EMPTY;
            endcase
    end

    always_comb begin
        out_valid = state != EMPTY;
`ifdef PIPE_SKID_EN
        in_ready  = state != SKID;
`else
        in_ready  = state == EMPTY || out_ready;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_kill <= 1'b0;
            main_data <= RESET_VAL;
        end else if (load_main) begin
            main_kill <= in_kill;
            main_data <= in_data;
        end else if (skid_to_main) begin
            main_kill <= skid_kill;
            main_data <= skid_data;
        end
    end

    // Masking is applied on the way out so write enables cannot leak from an empty or killed slot.
    assign out_killed = out_valid && main_kill;
    assign out_data   = (out_valid && !main_kill) ? main_data : main_data & ~KILL_MASK;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// tb_pipeline_stage_reg: randomized bench checking pipeline_stage_reg against a queue model.
module tb_pipeline_stage_reg;

    localparam int          W  = 32;
    localparam logic [W-1:0] KM = 32'h1;
    localparam logic [W-1:0] RV = 32'h1234_5671;
`ifdef PIPE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, in_kill, out_valid, out_ready, out_killed;
    logic [W-1:0] in_data, out_data;
    int checks = 0;
    int errors = 0;
    logic [W:0] q[$];

    always #5 clk = ~clk;

    pipeline_stage_reg #(
        .DATA_W    (W),
        .KILL_MASK (KM),
        .RESET_VAL (RV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kill    (in_kill),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_killed (out_killed),
        .out_data   (out_data)
    );

    function automatic logic model_ready();
        return DEPTH == 2 ? q.size() < 2 : (q.size() == 0 || out_ready);
    endfunction

    function automatic logic [W+2:0] model_vec();
        logic v, k;
        logic [W-1:0] d;
        v = q.size() > 0;
        k = v ? q[0][W] : 1'b0;
        d = v ? (k ? q[0][W-1:0] & ~KM : q[0][W-1:0]) : '0;
        return {v, k, model_ready(), d};
    endfunction

    function automatic logic [W+2:0] dut_vec();
        return {out_valid, out_killed, in_ready, out_data & ((q.size() > 0) ? {W{1'b1}} : KM)};
    endfunction

    task automatic tick();
        logic acc, pop;
        acc = !rst && !flush && in_valid && model_ready();
        pop = !rst && !flush && q.size() > 0 && out_ready;
        @(posedge clk);
        if (rst || flush)
            q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back({in_kill, in_data});
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL reset: got %h want %h", dut_vec(), model_vec());
            end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: ready=%b valid=%b data=%h", in_ready, out_valid, out_data);
            end
            tick();
        end
    endtask

    task automatic test_stream();
        int seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = i < 8;
            in_data  = 32'hA5A5_0000 + i;
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL stream: got %h want %h", dut_vec(), model_vec());
            end
            if (out_valid && out_ready) seen++;
            tick();
        end
        checks++;
        if (seen !== 8) begin
            errors++;
            $display("FAIL stream_count: got %0d want 8", seen);
        end
    endtask

    task automatic test_stall();
        int acc_n = 0;
        logic [W-1:0] held = '0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = $urandom;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom;
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL stall: got %h want %h", dut_vec(), model_vec());
            end
            if (i > 0) begin
                checks++;
                if (out_data !== held) begin
                    errors++;
                    $display("FAIL stall_stable: got %h want %h", out_data, held);
                end
            end
            held = out_data;
            if (in_valid && in_ready) acc_n++;
            tick();
        end
        checks++;
        if (acc_n !== DEPTH - 1) begin
            errors++;
            $display("FAIL stall_accepts: got %0d want %0d", acc_n, DEPTH - 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL stall_release: got %h want %h", dut_vec(), model_vec());
            end
            tick();
        end
    endtask

    task automatic test_kill();
        in_valid  = 1'b1;
        in_kill   = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_kill  = 1'b0;
        @(negedge clk);
        checks++;
        if (out_killed !== 1'b1 || out_data !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL kill: got killed=%b data=%h want 1 fffffffe", out_killed, out_data);
        end
        tick();
        for (int i = 0; i < 14; i++) begin
            in_valid = i < 12;
            in_kill  = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL kill_mix: got %h want %h", dut_vec(), model_vec());
            end
            tick();
        end
        in_kill = 1'b0;
    endtask

    task automatic test_flush();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom;
            tick();
        end
        flush   = 1'b1;
        in_data = 32'hDEAD_BEEF;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL flush: got %h want %h", dut_vec(), model_vec());
            end
            tick();
        end
    endtask

    task automatic test_reset_stall();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom;
            in_kill = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_kill  = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_killed !== 1'b0 || out_data[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: valid=%b ready=%b killed=%b data=%h want 0 1 0 xxxxxxx0",
                     out_valid, in_ready, out_killed, out_data);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            flush     = $urandom_range(0, 19) == 0;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            in_kill   = $urandom_range(0, 3) == 0;
            in_data   = $urandom;
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
            tick();
        end
        flush = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_kill   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_kill();
        test_flush();
        test_reset_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
